// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Pick one byte out of a block; byte 0 lives in the low bits.
  function automatic logic [7:0] byte_sel(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFF_W-1:0]   off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_fsm.sv
// Miss-handling controller: write back a dirty victim, fetch the block,
// then spend one cycle installing it before handing control back to IDLE.
module dcache_fsm
  import dcache_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       hit,
  input  logic       dirty,
  input  logic       req,
  input  logic       MEM_BUSYWAIT,
  output logic [1:0] state,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic       fill
);

  state_t state_reg;

  assign state = state_reg;

  // State register with registered memory strobes; requests are only
  // released on an edge where the memory reports it is no longer busy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
      MEM_READ  <= 1'b0;
      MEM_WRITE <= 1'b0;
      fill      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          fill <= 1'b0;
          if (req && !hit) begin
            if (dirty) begin
              state_reg <= WRITEBACK;
              MEM_WRITE <= 1'b1;
            end else begin
              state_reg <= FETCH;
              MEM_READ  <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state_reg <= FETCH;
            MEM_WRITE <= 1'b0;
            MEM_READ  <= 1'b1;
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state_reg <= UPDATE;
            MEM_READ  <= 1'b0;
            fill      <= 1'b1;
          end
        end
        UPDATE: begin
          state_reg <= IDLE;
          fill      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
          fill      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache: byte-wide CPU port, block-wide memory
// port. Hits are serviced combinationally; misses stall the CPU via BUSYWAIT.
module dcache
  import dcache_pkg::*;
#(
  parameter int NLINES      = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [7:0]                 ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [TAG_W+IDX_W-1:0]     MEM_ADDRESS,
  output logic [BLOCK_BYTES*8-1:0]   MEM_WRITEDATA,
  input  logic [BLOCK_BYTES*8-1:0]   MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
);

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   addr_tag;
  logic [OFF_W-1:0]   off;

  logic               valid_mem [NLINES];
  logic               dirty_mem [NLINES];
  logic [TAG_W-1:0]   tag_mem   [NLINES];
  logic [BLOCK_W-1:0] data_mem  [NLINES];

  logic [BLOCK_W-1:0] fill_buf;
  logic [7:0]         readdata_reg;
  logic [7:0]         sel_byte;
  logic [1:0]         fsm_state;
  state_t             state;
  logic               hit, req, idle, fill, line_dirty, rd_hit, wr_hit;

  assign idx      = ADDRESS[OFF_W +: IDX_W];
  assign addr_tag = ADDRESS[OFF_W+IDX_W +: TAG_W];
  assign off      = ADDRESS[OFF_W-1:0];

  assign state      = state_t'(fsm_state);
  assign idle       = (state == IDLE);
  assign req        = READ | WRITE;
  assign hit        = valid_mem[idx] && (tag_mem[idx] == addr_tag);
  assign line_dirty = valid_mem[idx] && dirty_mem[idx];
  assign rd_hit     = idle && READ && hit;
  assign wr_hit     = idle && WRITE && hit;
  assign sel_byte   = byte_sel(data_mem[idx], off);

  dcache_fsm u_fsm (
    .CLK          (CLK),
    .RESET        (RESET),
    .hit          (hit),
    .dirty        (line_dirty),
    .req          (req),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .state        (fsm_state),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .fill         (fill)
  );

  // Per-line storage: a fill installs a clean block, a write hit merges one
  // byte and marks the line dirty. The two never coincide (fill is non-IDLE).
  generate
    for (genvar gi = 0; gi < NLINES; gi++) begin : g_line
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          valid_mem[gi] <= 1'b0;
          dirty_mem[gi] <= 1'b0;
          tag_mem[gi]   <= '0;
          data_mem[gi]  <= '0;
        end else if (fill && idx == IDX_W'(gi)) begin
          valid_mem[gi] <= 1'b1;
          dirty_mem[gi] <= 1'b0;
          tag_mem[gi]   <= addr_tag;
          data_mem[gi]  <= fill_buf;
        end else if (wr_hit && idx == IDX_W'(gi)) begin
          dirty_mem[gi]                    <= 1'b1;
          data_mem[gi][{off, 3'b000} +: 8] <= WRITEDATA;
        end
      end
    end
  endgenerate

  // Track the fetched block every FETCH cycle; the last sample is the one
  // taken as MEM_BUSYWAIT falls, which is when memory data is valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      fill_buf <= '0;
    else if (state == FETCH)
      fill_buf <= MEM_READDATA;
  end

  // Remember the last byte handed to the CPU so READDATA holds when idle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      readdata_reg <= '0;
    else if (rd_hit)
      readdata_reg <= sel_byte;
  end

  assign READDATA = rd_hit ? sel_byte : readdata_reg;

  // Stall is gated by reset so every CPU-side output reads 0 while held.
  assign BUSYWAIT = RESET && ((req && !hit) || !idle);

  assign MEM_WRITEDATA = (state == WRITEBACK) ? data_mem[idx] : '0;

  // Victim address during writeback, requested address during fetch.
  always_comb begin
    MEM_ADDRESS = '0;
    case (state)
      WRITEBACK: MEM_ADDRESS = {tag_mem[idx], idx};
      FETCH:     MEM_ADDRESS = {addr_tag, idx};
      default:   MEM_ADDRESS = '0;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: a flat byte-addressed view of memory is the
// reference for every load, and a per-index residency table predicts stalls.
module tb_dcache;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mem [64];
  logic [7:0]  shadow [256];
  int          lat = 0;
  int          cnt = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  logic [5:0]  last_wr_addr = '0;
  logic [5:0]  last_rd_addr = '0;
  logic [31:0] last_wr_data = '0;
  bit          res_valid [8];
  logic [5:0]  res_blk   [8];
  bit          res_dirty [8];

  bit          pend = 1'b0;
  logic        p_rd, p_wr;
  logic [5:0]  p_addr;
  logic [31:0] p_data;

  dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory model: busy for 'lat' cycles per request, then one ready cycle.
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < lat);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) cnt <= 0;
    else if (MEM_READ || MEM_WRITE)               cnt <= cnt + 1;
    else                                          cnt <= 0;
  end

  function automatic logic [31:0] shadow_block(input logic [5:0] b);
    return {shadow[{b, 2'd3}], shadow[{b, 2'd2}], shadow[{b, 2'd1}], shadow[{b, 2'd0}]};
  endfunction

  // Memory-side monitor: handshake stability and writeback contents.
  always @(negedge CLK) begin
    if (pend && RESET) begin
      compared++;
      if (MEM_READ !== p_rd || MEM_WRITE !== p_wr || MEM_ADDRESS !== p_addr ||
          (p_wr && MEM_WRITEDATA !== p_data)) begin
        mismatched++;
        $display("FAIL mem_hold: rd=%b wr=%b addr=%h data=%h, required rd=%b wr=%b addr=%h data=%h",
                 MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, p_rd, p_wr, p_addr, p_data);
      end
    end
    pend   = (MEM_READ || MEM_WRITE) && MEM_BUSYWAIT && RESET;
    p_rd   = MEM_READ;
    p_wr   = MEM_WRITE;
    p_addr = MEM_ADDRESS;
    p_data = MEM_WRITEDATA;
    if (RESET && (MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
      if (MEM_WRITE) begin
        compared++;
        if (MEM_WRITEDATA !== shadow_block(MEM_ADDRESS)) begin
          mismatched++;
          $display("FAIL wb_data: block %h got %h, required %h",
                   MEM_ADDRESS, MEM_WRITEDATA, shadow_block(MEM_ADDRESS));
        end
        mem[MEM_ADDRESS] = MEM_WRITEDATA;
        last_wr_addr = MEM_ADDRESS;
        last_wr_data = MEM_WRITEDATA;
        wr_count++;
      end else begin
        last_rd_addr = MEM_ADDRESS;
        rd_count++;
      end
    end
  end

  // Architectural state after reset: memory contents, nothing cached.
  task automatic sync_model();
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++)
        shadow[b*4+k] = mem[b][k*8 +: 8];
    for (int i = 0; i < 8; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
      res_blk[i]   = '0;
    end
  endtask

  // One CPU access with predicted stall length, memory traffic and data.
  task automatic access(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    int       idx, busy_cycles, exp_busy, exp_wr, exp_rd, wr0, rd0;
    bit       miss, vdirty;
    logic [5:0] blk;
    idx    = int'(addr[4:2]);
    blk    = addr[7:2];
    miss   = !(res_valid[idx] && res_blk[idx] == blk);
    vdirty = miss && res_valid[idx] && res_dirty[idx];
    exp_busy = miss ? (3 + lat + (vdirty ? 1 + lat : 0)) : 0;
    exp_wr = vdirty ? 1 : 0;
    exp_rd = miss ? 1 : 0;
    wr0 = wr_count;
    rd0 = rd_count;
    @(negedge CLK);
    READ = !wr; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    #1;
    busy_cycles = 0;
    while (BUSYWAIT && busy_cycles < 200) begin
      busy_cycles++;
      @(negedge CLK);
      #1;
    end
    compared++;
    if (busy_cycles != exp_busy) begin
      mismatched++;
      $display("FAIL stall: addr %h got %0d busy cycles, required %0d", addr, busy_cycles, exp_busy);
    end
    if (!wr) begin
      compared++;
      if (READDATA !== shadow[addr]) begin
        mismatched++;
        $display("FAIL readdata: addr %h got %h, required %h", addr, READDATA, shadow[addr]);
      end
    end
    @(posedge CLK);
    #1;
    compared++;
    if ((wr_count - wr0) != exp_wr || (rd_count - rd0) != exp_rd) begin
      mismatched++;
      $display("FAIL mem_traffic: addr %h got wr=%0d rd=%0d, required wr=%0d rd=%0d",
               addr, wr_count - wr0, rd_count - rd0, exp_wr, exp_rd);
    end
    $display("%s %h data=%h lat=%0d %s%s busy=%0d", wr ? "WR" : "RD", addr, wr ? wd : READDATA,
             lat, miss ? "miss" : "hit", vdirty ? "+wb" : "", busy_cycles);
    if (miss) begin
      res_valid[idx] = 1'b1;
      res_blk[idx]   = blk;
      res_dirty[idx] = 1'b0;
    end
    if (wr) begin
      shadow[addr]   = wd;
      res_dirty[idx] = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    compared++;
    if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 ||
        MEM_ADDRESS !== 6'h0 || MEM_WRITEDATA !== 32'h0 || READDATA !== 8'h0) begin
      mismatched++;
      $display("FAIL %s: busy=%b mrd=%b mwr=%b maddr=%h mwd=%h rdata=%h, required all 0",
               tag, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, READDATA);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    #1;
    check_outputs_zero("reset_state");
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_outputs_zero("after_release");
  endtask

  // Clean fill, write hit, then dirty eviction of the same line.
  task automatic test_directed();
    lat = 0;
    access(1'b0, 8'h05, 8'h00);
    compared++;
    if (last_rd_addr !== 6'h01 || READDATA !== 8'h22) begin
      mismatched++;
      $display("FAIL first_fill: fetch addr %h data %h, required 01 and 22", last_rd_addr, READDATA);
    end
    access(1'b1, 8'h06, 8'hAB);
    access(1'b0, 8'h06, 8'h00);
    compared++;
    if (READDATA !== 8'hAB) begin
      mismatched++;
      $display("FAIL write_hit_read: got %h, required ab", READDATA);
    end
    access(1'b0, 8'h25, 8'h00);
    compared++;
    if (last_wr_addr !== 6'h01 || last_wr_data !== 32'h44AB2211 || last_rd_addr !== 6'h09) begin
      mismatched++;
      $display("FAIL dirty_evict: wb %h/%h fetch %h, required 01/44ab2211 fetch 09",
               last_wr_addr, last_wr_data, last_rd_addr);
    end
  endtask

  // Write miss on a clean line, then prove the merged byte made it dirty.
  task automatic test_write_miss();
    lat = 1;
    access(1'b1, 8'h10, 8'h5C);
    compared++;
    if (last_rd_addr !== 6'h04) begin
      mismatched++;
      $display("FAIL write_miss_fetch: got %h, required 04", last_rd_addr);
    end
    access(1'b0, 8'h10, 8'h00);
    access(1'b0, 8'h30, 8'h00);
    compared++;
    if (last_wr_addr !== 6'h04 || last_wr_data[7:0] !== 8'h5C) begin
      mismatched++;
      $display("FAIL write_miss_dirty: wb %h/%h, required 04 with low byte 5c", last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_busy_stretch();
    lat = 5;
    access(1'b0, 8'h48, 8'h00);
    access(1'b1, 8'h4B, 8'h3D);
    access(1'b0, 8'hC8, 8'h00);
    lat = 0;
  endtask

  // Write then read the same byte on consecutive edges; READDATA must hold.
  task automatic test_back_to_back();
    logic [7:0] a, d, held;
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(0, 2);
      a = 8'($urandom);
      d = 8'($urandom);
      access(1'b0, a, 8'h00);
      access(1'b1, a, d);
      access(1'b0, a, 8'h00);
    end
    held = READDATA;
    idle_cycles(2);
    ADDRESS = 8'($urandom);
    #1;
    compared++;
    if (READDATA !== held) begin
      mismatched++;
      $display("FAIL readdata_hold: got %h, required %h", READDATA, held);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 200; i++) begin
      lat = $urandom_range(0, 3);
      a = {2'($urandom_range(0, 3)), 1'b0, 5'($urandom)};
      if ($urandom_range(0, 9) == 0) a = 8'hFF;
      access(1'($urandom_range(0, 1)), a, 8'($urandom));
    end
  endtask

  // Reset while a dirty victim is being written back.
  task automatic test_reset_mid_wb();
    int w;
    lat = 0;
    access(1'b0, 8'h25, 8'h00);
    access(1'b1, 8'h26, 8'h77);
    lat = 4;
    @(negedge CLK);
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h05;
    #1;
    w = 0;
    while (!MEM_WRITE && w < 20) begin
      @(negedge CLK);
      #1;
      w++;
    end
    compared++;
    if (MEM_WRITE !== 1'b1) begin
      mismatched++;
      $display("FAIL wb_start: MEM_WRITE=%b, required 1", MEM_WRITE);
    end
    #2;
    RESET = 1'b0;
    #1;
    check_outputs_zero("reset_mid_wb");
    @(negedge CLK);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    sync_model();
    lat = 1;
    access(1'b0, 8'h05, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'h44332211;
    sync_model();
    test_reset();
    test_directed();
    test_write_miss();
    test_busy_stretch();
    test_back_to_back();
    test_random();
    test_reset_mid_wb();
    idle_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
